mul_div_seq: RTL and testbench

//  Parametrised multi-cycle integer multiply/divide unit for the EX stage.

---
 rtl/mul_div_seq_if.sv | 29 ++
 rtl/mul_div_seq.sv | 144 ++++++++++++++
 tb/tb_mul_div_seq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mul_div_seq_if.sv
// Handshake and data bundle between the EX stage and the multi-cycle mul/div unit.
interface mul_div_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             cancel;
  logic [1:0]       mdOp;
  logic [WIDTH-1:0] din1;
  logic [WIDTH-1:0] din2;
  logic             hiWe;
  logic             loWe;
  logic             busy;
  logic             done;
  logic             divZero;
  logic [WIDTH-1:0] doutHi;
  logic [WIDTH-1:0] doutLo;

  // Pipeline side: issues requests and HI/LO moves, observes status and results.
  modport master (
    output start, cancel, mdOp, din1, din2, hiWe, loWe,
    input  busy, done, divZero, doutHi, doutLo
  );

  // Unit side.
  modport slave (
    input  start, cancel, mdOp, din1, din2, hiWe, loWe,
    output busy, done, divZero, doutHi, doutLo
  );
endinterface

// File: rtl/mul_div_seq.sv
// Multi-cycle radix-2 multiply/divide unit with architectural HI/LO registers.
// Signed ops run on magnitudes; the sign fix-up happens in a single FIX cycle.
module mul_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_div_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_mul;     // 1: multiply, 0: divide
  logic               r_sq;      // negate product / quotient
  logic               r_sr;      // negate remainder (dividend sign)
  logic               r_dz;      // divide by zero in flight
  logic [WIDTH-1:0]   r_b;       // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] r_acc;     // mult: {partial, multiplier}; div: {rem, dividend/quotient}
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_divz;

  logic               w_sgn;
  logic               w_neg1;
  logic               w_neg2;
  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;
  logic [WIDTH:0]     w_madd;
  logic [WIDTH:0]     w_rsh;
  logic [WIDTH:0]     w_sub;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;
  logic [WIDTH-1:0]   w_lo_div;
  logic [WIDTH-1:0]   w_hi_div;

  // Operand magnitudes and one radix-2 step of either algorithm.
  always_comb begin
    w_sgn  = ~bus.mdOp[0];
    w_neg1 = w_sgn & bus.din1[WIDTH-1];
    w_neg2 = w_sgn & bus.din2[WIDTH-1];
    w_abs1 = w_neg1 ? -bus.din1 : bus.din1;
    w_abs2 = w_neg2 ? -bus.din2 : bus.din2;

    // Shift-add: add multiplicand into the upper half when the multiplier LSB is set,
    // then shift the whole accumulator right keeping the carry.
    w_madd = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);

    // Restoring divide: shift next dividend bit into the remainder and try the subtract.
    // The shifted remainder needs WIDTH+1 bits since it can reach 2*divisor-1.
    w_rsh = r_acc[2*WIDTH-1:WIDTH-1];
    w_sub = w_rsh - {1'b0, r_b};

    if (r_mul)
      w_step = {w_madd, r_acc[WIDTH-1:1]};
    else if (!w_sub[WIDTH])
      w_step = {w_sub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    else
      w_step = {w_rsh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    // Sign fix-up. Divide by zero naturally leaves rem=|dividend| and q=all ones;
    // restoring the dividend sign on rem gives back din1, and LO is forced to all ones.
    w_prod   = r_sq ? -r_acc : r_acc;
    w_q      = r_acc[WIDTH-1:0];
    w_r      = r_acc[2*WIDTH-1:WIDTH];
    w_lo_div = r_dz ? '1 : (r_sq ? -w_q : w_q);
    w_hi_div = r_sr ? -w_r : w_r;
  end

  // Control FSM, datapath registers and HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mul   <= 1'b0;
      r_sq    <= 1'b0;
      r_sr    <= 1'b0;
      r_dz    <= 1'b0;
      r_b     <= '0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_divz  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.hiWe) r_hi <= bus.din1;
          if (bus.loWe) r_lo <= bus.din1;
          if (bus.start && !bus.cancel) begin
            r_mul   <= bus.mdOp[1];
            r_sq    <= w_neg1 ^ w_neg2;
            r_sr    <= w_neg1;
            r_dz    <= !bus.mdOp[1] && (bus.din2 == '0);
            r_b     <= bus.mdOp[1] ? w_abs1 : w_abs2;
            r_acc   <= bus.mdOp[1] ? {{WIDTH{1'b0}}, w_abs2} : {{WIDTH{1'b0}}, w_abs1};
            r_cnt   <= CW'(WIDTH);
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          if (bus.cancel) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_step;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (r_mul) begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end else begin
            r_hi <= w_hi_div;
            r_lo <= w_lo_div;
          end
          r_divz  <= r_dz;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.divZero = r_divz;
  assign bus.doutHi  = r_hi;
  assign bus.doutLo  = r_lo;
endmodule

// File: tb/tb_mul_div_seq.sv
// Directed bench for mul_div_seq: a 32-bit and an 8-bit instance on one clock/reset.
module tb_mul_div_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mul_div_seq_if #(.WIDTH(32)) bus ();
  mul_div_seq_if #(.WIDTH(8))  bus8 ();

  mul_div_seq #(.WIDTH(32)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  mul_div_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op on the 32-bit unit; n = edges after the start edge until done is seen.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n, output logic busy1);
    @(negedge clk);
    bus.mdOp = op; bus.din1 = a; bus.din2 = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    busy1 = bus.busy;
    n = 0;
    while (!bus.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int   n;
    logic b1;
    logic seen;

    bus.start = 0; bus.cancel = 0; bus.mdOp = 0; bus.din1 = 0; bus.din2 = 0;
    bus.hiWe = 0; bus.loWe = 0;
    bus8.start = 0; bus8.cancel = 0; bus8.mdOp = 0; bus8.din1 = 0; bus8.din2 = 0;
    bus8.hiWe = 0; bus8.loWe = 0;

    // Reset state
    #12;
    chk("rst32", {bus.busy, bus.done, bus.divZero, bus.doutHi, bus.doutLo}, 64'h0);
    chk("rst8",  {bus8.busy, bus8.done, bus8.divZero, bus8.doutHi, bus8.doutLo}, 64'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // 1. div 5 / -3
    run_op(2'b00, 32'd5, 32'hFFFF_FFFD, n, b1);
    chk("div_busy", 64'(b1), 64'd1);
    chk("div_lat", 64'(n), 64'd33);
    chk("div_hi", 64'(bus.doutHi), 64'h0000_0002);
    chk("div_lo", 64'(bus.doutLo), 64'hFFFF_FFFF);
    chk("div_busy_done", 64'(bus.busy), 64'd0);

    // 2. multu and signed mult
    run_op(2'b11, 32'hABCD_CDEF, 32'h1234_5678, n, b1);
    chk("multu_hi", 64'(bus.doutHi), 64'h0C37_9850);
    chk("multu_lo", 64'(bus.doutLo), 64'h4E32_D208);
    run_op(2'b10, 32'hFFFF_FFFB, 32'd3, n, b1);
    chk("mult_hi", 64'(bus.doutHi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(bus.doutLo), 64'hFFFF_FFF1);

    // 3. divide by zero, then a clearing multiply
    run_op(2'b01, 32'd7, 32'd0, n, b1);
    chk("dz_lat", 64'(n), 64'd33);
    chk("dz_hi", 64'(bus.doutHi), 64'h0000_0007);
    chk("dz_lo", 64'(bus.doutLo), 64'hFFFF_FFFF);
    chk("dz_flag", 64'(bus.divZero), 64'd1);
    run_op(2'b11, 32'd2, 32'd2, n, b1);
    chk("dzclr_lo", 64'(bus.doutLo), 64'd4);
    chk("dzclr_flag", 64'(bus.divZero), 64'd0);

    // Signed divide MIN / -1
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, n, b1);
    chk("min_lo", 64'(bus.doutLo), 64'h8000_0000);
    chk("min_hi", 64'(bus.doutHi), 64'h0);

    // 4. preload HI/LO, then cancel a divu mid-flight
    @(negedge clk);
    bus.hiWe = 1; bus.loWe = 1; bus.din1 = 32'h1234_5678;
    @(posedge clk); #1;
    bus.hiWe = 0; bus.loWe = 0;
    chk("pre_hi", 64'(bus.doutHi), 64'h1234_5678);
    chk("pre_lo", 64'(bus.doutLo), 64'h1234_5678);
    @(negedge clk);
    bus.mdOp = 2'b01; bus.din1 = 32'd100; bus.din2 = 32'd7; bus.start = 1;
    @(posedge clk); #1;
    bus.start = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("can_busy_pre", 64'(bus.busy), 64'd1);
    @(negedge clk);
    bus.cancel = 1;
    @(posedge clk); #1;
    bus.cancel = 0;
    chk("can_busy", 64'(bus.busy), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    chk("can_nodone", 64'(seen), 64'd0);
    chk("can_hi", 64'(bus.doutHi), 64'h1234_5678);
    chk("can_lo", 64'(bus.doutLo), 64'h1234_5678);
    chk("can_dz", 64'(bus.divZero), 64'd0);

    // 5. mult 3*4 with an ignored request while busy
    @(negedge clk);
    bus.mdOp = 2'b10; bus.din1 = 32'd3; bus.din2 = 32'd4; bus.start = 1;
    @(posedge clk); #1;
    bus.start = 0;
    @(negedge clk);
    bus.start = 1; bus.hiWe = 1; bus.mdOp = 2'b11; bus.din1 = 32'h99; bus.din2 = 32'h77;
    @(negedge clk);
    bus.start = 0; bus.hiWe = 0;
    n = 0;
    while (!bus.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ign_lo", 64'(bus.doutLo), 64'h0000_000C);
    chk("ign_hi", 64'(bus.doutHi), 64'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("ign_idle", 64'(bus.busy), 64'd0);

    // Async reset mid-CALC
    @(negedge clk);
    bus.mdOp = 2'b01; bus.din1 = 32'd100; bus.din2 = 32'd7; bus.start = 1;
    @(posedge clk); #1;
    bus.start = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy", 64'(bus.busy), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst", {bus.busy, bus.done, bus.divZero, bus.doutHi, bus.doutLo}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 6. WIDTH=8: 0x80 / 0xFF signed
    @(negedge clk);
    bus8.mdOp = 2'b00; bus8.din1 = 8'h80; bus8.din2 = 8'hFF; bus8.start = 1;
    @(posedge clk); #1;
    bus8.start = 0;
    n = 0;
    while (!bus8.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w8_lat", 64'(n), 64'd9);
    chk("w8_lo", 64'(bus8.doutLo), 64'h80);
    chk("w8_hi", 64'(bus8.doutHi), 64'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
